weight_loader: RTL

//  Write-side companion of the NPU weight memory. Accepts a serial stream of weight elements over a

---
 rtl/weight_loader_pkg.sv | 10 +
 rtl/weight_line_packer.sv | 56 +++++
 rtl/weight_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/weight_loader_pkg.sv
// rtl/weight_loader_pkg.sv - shared types and helpers for the weight loader
package weight_loader_pkg;

   typedef enum logic [1:0] {WL_IDLE, WL_LOAD, WL_DONE} weight_loader_state_t;

   function automatic int cnt_bits(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/weight_line_packer.sv
// rtl/weight_line_packer.sv - packs serial elements into one memory line, LSB element first
module weight_line_packer
   import weight_loader_pkg::*;
#(
   parameter int data_width  = 64,
   parameter int parallelism = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clear_i,
   input  logic                              accept_i,
   input  logic [data_width/parallelism-1:0] elem_i,
   output logic                              line_complete_o,
   output logic [data_width-1:0]             line_o
);

   localparam int cw = cnt_bits(parallelism);
   localparam int ew = data_width / parallelism;
   localparam logic [cw-1:0] last_k = cw'(parallelism - 1);

   logic [cw-1:0]         cnt_q, cnt_d;
   logic [data_width-1:0] shadow_q, shadow_d;

   always_comb begin
      cnt_d           = cnt_q;
      shadow_d        = shadow_q;
      line_complete_o = 1'b0;
      // line_o is the shadow with the current element already inserted at slot k
      line_o          = shadow_q;
      line_o[cnt_q*ew +: ew] = elem_i;
      if (clear_i) begin
         cnt_d    = '0;
         shadow_d = '0;
      end else if (accept_i) begin
         if (cnt_q == last_k) begin
            cnt_d           = '0;
            shadow_d        = '0;
            line_complete_o = 1'b1;
         end else begin
            cnt_d    = cnt_q + 1'b1;
            shadow_d = line_o;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         shadow_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

endmodule

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams weight elements into memory lines 0..num_weight_lines-1
module weight_loader
   import weight_loader_pkg::*;
#(
   parameter int num_weight_lines = 196,
   parameter int data_width       = 64,
   parameter int parallelism      = 4,
   parameter int address_width    = 10
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              in_valid,
   input  logic [data_width/parallelism-1:0] in_data,
   output logic                              in_ready,
   output logic                              wen,
   output logic [address_width-1:0]          wadd,
   output logic [data_width-1:0]             win,
   output logic                              busy,
   output logic                              done,
   output logic [address_width-1:0]          lines_written
);

   if ((data_width % parallelism) != 0 || (2**address_width) < num_weight_lines) begin : g_bad_params
      $error("weight_loader: illegal parameter combination");
   end

   localparam logic [address_width-1:0] last_line = address_width'(num_weight_lines - 1);

   weight_loader_state_t    state_q, state_d;
   logic                    wen_q, wen_d;
   logic [address_width-1:0] wadd_q, wadd_d;
   logic [data_width-1:0]   win_q, win_d;
   logic [address_width-1:0] lines_q, lines_d;
   logic [address_width-1:0] idx_q, idx_d;

   logic                    transfer;
   logic                    begin_load;
   logic                    line_complete;
   logic [data_width-1:0]   packed_line;

   assign in_ready   = (state_q == WL_LOAD);
   assign transfer   = in_valid && in_ready;
   assign begin_load = start && (state_q != WL_LOAD);

   weight_line_packer #(
      .data_width  (data_width),
      .parallelism (parallelism)
   ) u_packer (
      .clk             (clk),
      .rst             (rst),
      .clear_i         (begin_load),
      .accept_i        (transfer),
      .elem_i          (in_data),
      .line_complete_o (line_complete),
      .line_o          (packed_line)
   );

   always_comb begin
      state_d = state_q;
      wen_d   = 1'b0;
      wadd_d  = wadd_q;
      win_d   = win_q;
      lines_d = lines_q;
      idx_d   = idx_q;
      case (state_q)
         WL_IDLE, WL_DONE: begin
            if (start) begin
               state_d = WL_LOAD;
               lines_d = '0;
               idx_d   = '0;
            end
         end
         WL_LOAD: begin
            if (line_complete) begin
               wen_d   = 1'b1;
               wadd_d  = idx_q;
               win_d   = packed_line;
               lines_d = lines_q + 1'b1;
               // idx stays at the last line so it never leaves the legal address range
               if (idx_q == last_line) state_d = WL_DONE;
               else                    idx_d   = idx_q + 1'b1;
            end
         end
         default: state_d = WL_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WL_IDLE;
         wen_q   <= 1'b0;
         wadd_q  <= '0;
         win_q   <= '0;
         lines_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         wadd_q  <= wadd_d;
         win_q   <= win_d;
         lines_q <= lines_d;
         idx_q   <= idx_d;
      end
   end

   assign wen           = wen_q;
   assign wadd          = wadd_q;
   assign win           = win_q;
   assign lines_written = lines_q;
   assign busy          = (state_q == WL_LOAD);
   assign done          = (state_q == WL_DONE);

endmodule
